// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - serial bit-pattern detector with optional saturating match counter
// Optional feature macro: SEQ_PATDET_COUNT_EN (match_count register; tied to 0 when undefined)
module seq_pattern_detector #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16,
    parameter int LW    = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in,
    input  logic [PAT_W-1:0] pat,
    input  logic [LW-1:0]    pat_len,
    input  logic             overlap,
    input  logic             clr,
    output logic             out,
    output logic [CNT_W-1:0] match_count
);

    logic [PAT_W-1:0] r_hist;
    logic [LW-1:0]    r_fill;
    logic             r_out;

    logic [LW-1:0]    w_len;
    logic [PAT_W-1:0] w_mask;
    logic [PAT_W-1:0] w_cand;
    logic             w_fill_ok;
    logic             w_match;

    // Lengths beyond PAT_W are clamped to the full history window.
    always_comb begin
        w_len = pat_len;
        if (pat_len > LW'(PAT_W)) begin
            w_len = LW'(PAT_W);
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(w_len));
        end
    end

    always_comb begin
        w_cand    = {r_hist[PAT_W-2:0], in};
        w_fill_ok = ({1'b0, r_fill} + (LW+1)'(1)) >= {1'b0, w_len};
        w_match   = in_valid && (w_len != '0) && w_fill_ok &&
                    (((w_cand ^ pat) & w_mask) == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
            r_fill <= '0;
            r_out  <= 1'b0;
        end else if (clr) begin
            r_hist <= '0;
            r_fill <= '0;
            r_out  <= 1'b0;
        end else if (in_valid) begin
            r_hist <= w_cand;
            r_out  <= w_match;
            // A non-overlapping match retires the whole window from future matches.
            if (w_match && !overlap) begin
                r_fill <= '0;
            end else if (r_fill != LW'(PAT_W)) begin
                r_fill <= r_fill + LW'(1);
            end
        end else begin
            r_out <= 1'b0;
        end
    end

    assign out = r_out;

`ifdef SEQ_PATDET_COUNT_EN
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (w_match && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign match_count = r_count;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - directed and randomized checks of seq_pattern_detector against a bit-queue model
module tb_seq_pattern_detector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tb_valid = 1'b0;
    logic       tb_in = 1'b0;
    logic [7:0] tb_pat = 8'h00;
    logic [3:0] tb_len = 4'd0;
    logic       tb_ovl = 1'b0;
    logic       tb_clr = 1'b0;

    logic        out_a, out_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: every bit since the last reset/clr, bits still eligible, expected outputs.
    bit q[$];
    int elig;
    bit exp_out;
    int exp_cnt_a, exp_cnt_b;

    always #5 clk = ~clk;

    seq_pattern_detector #(.PAT_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(tb_valid), .in(tb_in), .pat(tb_pat),
        .pat_len(tb_len), .overlap(tb_ovl), .clr(tb_clr), .out(out_a), .match_count(cnt_a)
    );

    seq_pattern_detector #(.PAT_W(8), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(tb_valid), .in(tb_in), .pat(tb_pat),
        .pat_len(tb_len), .overlap(tb_ovl), .clr(tb_clr), .out(out_b), .match_count(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_count(input int c);
`ifdef SEQ_PATDET_COUNT_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".out"}, 32'(out_a), 32'(exp_out));
        chk({tag, ".out_sat"}, 32'(out_b), 32'(exp_out));
        chk({tag, ".cnt"}, 32'(cnt_a), 32'(exp_count(exp_cnt_a)));
        chk({tag, ".cnt_sat"}, 32'(cnt_b), 32'(exp_count(exp_cnt_b)));
    endtask

    task automatic model_clear();
        q.delete();
        elig      = 0;
        exp_out   = 1'b0;
        exp_cnt_a = 0;
        exp_cnt_b = 0;
    endtask

    // One clock: drive at negedge, update model, check after the rising edge.
    task automatic step(input bit v, input bit b, input bit c, input string tag);
        int  len;
        bit  m;
        tb_valid = v;
        tb_in    = b;
        tb_clr   = c;
        if (c) begin
            model_clear();
        end else if (v) begin
            q.push_back(b);
            len = (int'(tb_len) > 8) ? 8 : int'(tb_len);
            m = (len >= 1) && (elig + 1 >= len);
            for (int k = 0; k < len && m; k++) begin
                if (q[q.size() - 1 - k] != tb_pat[k]) m = 1'b0;
            end
            elig    = (m && !tb_ovl) ? 0 : elig + 1;
            exp_out = m;
            if (m) begin
                exp_cnt_a = (exp_cnt_a == 65535) ? 65535 : exp_cnt_a + 1;
                exp_cnt_b = (exp_cnt_b == 3) ? 3 : exp_cnt_b + 1;
            end
            if (q.size() > 40) void'(q.pop_front());
        end else begin
            exp_out = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all({tag, ".async"});
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic setup(input logic [7:0] p, input logic [3:0] l, input logic o);
        tb_pat = p;
        tb_len = l;
        tb_ovl = o;
    endtask

    task automatic send(input logic [31:0] bits, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, tag);
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        do_reset("reset");
        check_all("reset.idle");

        setup(8'h05, 4'd3, 1'b1);
        send(32'b10101, 5, "overlap");
        chk("overlap.final_cnt_expect2", 32'(exp_count(2)), 32'(cnt_a));

        do_reset("r2");
        setup(8'h05, 4'd3, 1'b0);
        send(32'b10101, 5, "nonoverlap");
        chk("nonoverlap.final_cnt_expect1", 32'(cnt_a), 32'(exp_count(1)));

        do_reset("r3");
        setup(8'h05, 4'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, (i != 1), 1'b0, "gaps.bit");
            if (i < 2) for (int g = 0; g < 3; g++) step(1'b0, g[0], 1'b0, "gaps.idle");
        end
        step(1'b0, 1'b1, 1'b0, "gaps.after");

        do_reset("r4");
        send(32'b10, 2, "rst_mid");
        do_reset("rst_mid.reset");
        send(32'b1, 1, "rst_mid.nomatch");
        send(32'b01, 2, "rst_mid.followup");
        send(32'b10, 2, "clr_mid");
        step(1'b1, 1'b1, 1'b1, "clr_mid.clr");
        send(32'b1, 1, "clr_mid.nomatch");
        send(32'b01, 2, "clr_mid.followup");

        do_reset("r5");
        setup(8'hFF, 4'd8, 1'b1);
        send(32'hFFF, 12, "sat");
        setup(8'hFF, 4'd0, 1'b1);
        send(32'hFFF, 12, "len0");
        do_reset("r6");
        setup(8'hFF, 4'd9, 1'b1);
        send(32'hFFF, 12, "len9");

        // Randomized traffic with occasional parameter changes, clears and resets.
        do_reset("r7");
        for (int n = 0; n < 4000; n++) begin
            if (n % 40 == 0) begin
                setup(8'($urandom), 4'($urandom_range(0, 10)), 1'($urandom));
                if ($urandom_range(0, 3) != 0) tb_len = 4'($urandom_range(1, 4));
            end
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rand.reset");
            end else begin
                step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 99) == 0, "rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
